// File: rtl/pc_sequencer_if.sv
// Bundle of control inputs and PC-side outputs shared between the
// next-PC / control logic (master) and the PC sequencer (slave).
interface pc_sequencer_if #(
    parameter int N     = 32,
    parameter int CNT_W = 32
);
    // Redirect and control requests from the datapath
    logic             stall;
    logic             branch_taken;
    logic [N-1:0]     branch_target;
    logic             jump_valid;
    logic [N-1:0]     jump_target;
    logic             trap_req;
    logic             trap_ret;

    // Sequencer state presented to fetch and the rest of the core
    logic [N-1:0]     pc;
    logic [N-1:0]     pc_plus4;
    logic             pc_valid;
    logic [N-1:0]     epc;
    logic [1:0]       cause;
    logic             in_handler;
    logic             halted;
    logic [CNT_W-1:0] adv_count;

    // Control side: drives requests, observes the PC
    modport master (
        output stall, branch_taken, branch_target, jump_valid, jump_target,
               trap_req, trap_ret,
        input  pc, pc_plus4, pc_valid, epc, cause, in_handler, halted,
               adv_count
    );

    // Sequencer side: consumes requests, produces the PC
    modport slave (
        input  stall, branch_taken, branch_target, jump_valid, jump_target,
               trap_req, trap_ret,
        output pc, pc_plus4, pc_valid, epc, cause, in_handler, halted,
               adv_count
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: holds the PC, picks the next one among
// sequential / branch / jump / trap entry / trap return, supports stall,
// records the trapping PC and cause, and halts on a fault inside the handler.
module pc_sequencer #(
    parameter int           N            = 32,
    parameter logic [N-1:0] RESET_VECTOR = 32'h0040_0000,
    parameter logic [N-1:0] TRAP_VECTOR  = 32'h0040_0180,
    parameter int           CNT_W        = 32
) (
    input  logic          clk,
    input  logic          reset,
    pc_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        RUN     = 2'd1,
        HANDLER = 2'd2,
        HALT    = 2'd3
    } state_t;

    localparam logic [1:0]       CAUSE_NONE       = 2'd0;
    localparam logic [1:0]       CAUSE_TRAP       = 2'd1;
    localparam logic [1:0]       CAUSE_MISALIGNED = 2'd2;
    localparam logic [N-1:0]     PC_STEP          = N'(4);
    localparam logic [CNT_W-1:0] CNT_STEP         = CNT_W'(1);

    state_t           state;
    logic [N-1:0]     pc_q;
    logic [N-1:0]     epc_q;
    logic [1:0]       cause_q;
    logic [CNT_W-1:0] adv_q;
    logic             pc_valid_q;
    logic             in_handler_q;
    logic             halted_q;

    logic             misaligned_jump;
    logic             misaligned_branch;
    logic             trap_event;
    logic [1:0]       trap_cause;
    logic             take_return;
    logic [N-1:0]     pc_plus4;
    logic [N-1:0]     next_pc;

    // Sequential address wraps naturally modulo 2^N; no fault on wrap.
    assign pc_plus4 = pc_q + PC_STEP;

    // Classify the current request: which events are traps, and which cause.
    always_comb begin
        misaligned_jump   = bus.jump_valid && (bus.jump_target[1:0] != 2'b00);
        misaligned_branch = !bus.jump_valid && bus.branch_taken
                            && (bus.branch_target[1:0] != 2'b00);
        trap_event        = bus.trap_req || misaligned_jump || misaligned_branch;
        trap_cause        = bus.trap_req ? CAUSE_TRAP : CAUSE_MISALIGNED;
        take_return       = bus.trap_ret && (state == HANDLER);
    end

    // Non-trap next PC: return beats jump beats branch beats sequential.
    always_comb begin
        next_pc = pc_plus4;
        if (take_return) begin
            next_pc = epc_q;
        end else if (bus.jump_valid) begin
            next_pc = bus.jump_target;
        end else if (bus.branch_taken) begin
            next_pc = bus.branch_target;
        end
    end

    // Single state machine owning the PC, trap records, counter and flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= BOOT;
            pc_q         <= RESET_VECTOR;
            epc_q        <= '0;
            cause_q      <= CAUSE_NONE;
            adv_q        <= '0;
            pc_valid_q   <= 1'b0;
            in_handler_q <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    state      <= RUN;
                    pc_valid_q <= 1'b1;
                end

                RUN, HANDLER: begin
                    if (trap_event) begin
                        if (state == RUN) begin
                            epc_q        <= pc_q;
                            cause_q      <= trap_cause;
                            pc_q         <= TRAP_VECTOR;
                            adv_q        <= adv_q + CNT_STEP;
                            state        <= HANDLER;
                            in_handler_q <= 1'b1;
                        end else begin
                            state        <= HALT;
                            halted_q     <= 1'b1;
                            pc_valid_q   <= 1'b0;
                            in_handler_q <= 1'b0;
                        end
                    end else if (!bus.stall) begin
                        pc_q  <= next_pc;
                        adv_q <= adv_q + CNT_STEP;
                        if (take_return) begin
                            state        <= RUN;
                            in_handler_q <= 1'b0;
                        end
                    end
                end

                HALT: begin
                    state <= HALT;
                end

                default: begin
                    state <= HALT;
                end
            endcase
        end
    end

    assign bus.pc         = pc_q;
    assign bus.pc_plus4   = pc_plus4;
    assign bus.pc_valid   = pc_valid_q;
    assign bus.epc        = epc_q;
    assign bus.cause      = cause_q;
    assign bus.in_handler = in_handler_q;
    assign bus.halted     = halted_q;
    assign bus.adv_count  = adv_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a default-size instance walks through
// boot, stall/priority, trap/return, misalignment, double fault and reset
// recovery; a narrow instance exercises PC and counter wraparound.
module tb_pc_sequencer;

    logic clk;
    logic reset;

    pc_sequencer_if #(.N(32), .CNT_W(32)) bus ();
    pc_sequencer_if #(.N(8),  .CNT_W(2))  sbus ();

    pc_sequencer #(
        .N(32), .RESET_VECTOR(32'h0040_0000), .TRAP_VECTOR(32'h0040_0180), .CNT_W(32)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    pc_sequencer #(
        .N(8), .RESET_VECTOR(8'hF8), .TRAP_VECTOR(8'h80), .CNT_W(2)
    ) dut_small (
        .clk(clk), .reset(reset), .bus(sbus)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef enum int {
        S_PC, S_VALID, S_EPC, S_CAUSE, S_HANDLER, S_HALTED, S_ADV, S_PLUS4,
        S_SPC, S_SADV, S_SPLUS4, S_SVALID
    } sel_t;

    typedef struct {
        string       tag;
        sel_t        sel;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   compare_count  = 0;
    int   mismatch_count = 0;

    function automatic logic [31:0] observed(sel_t s);
        case (s)
            S_PC:      return bus.pc;
            S_VALID:   return {31'd0, bus.pc_valid};
            S_EPC:     return bus.epc;
            S_CAUSE:   return {30'd0, bus.cause};
            S_HANDLER: return {31'd0, bus.in_handler};
            S_HALTED:  return {31'd0, bus.halted};
            S_ADV:     return bus.adv_count;
            S_PLUS4:   return bus.pc_plus4;
            S_SPC:     return {24'd0, sbus.pc};
            S_SADV:    return {30'd0, sbus.adv_count};
            S_SPLUS4:  return {24'd0, sbus.pc_plus4};
            S_SVALID:  return {31'd0, sbus.pc_valid};
            default:   return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic expect_val(input string tag, input sel_t sel, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic check_output();
        exp_t        e;
        logic [31:0] obs;
        while (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            obs = observed(e.sel);
            compare_count++;
            assert (obs === e.val) else begin
                mismatch_count++;
                $error("[TB] FAIL %s: observed %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic apply_stimulus(input logic st, input logic br, input logic [31:0] bt,
                                  input logic jv, input logic [31:0] jt,
                                  input logic tq, input logic tr);
        bus.stall         = st;
        bus.branch_taken  = br;
        bus.branch_target = bt;
        bus.jump_valid    = jv;
        bus.jump_target   = jt;
        bus.trap_req      = tq;
        bus.trap_ret      = tr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        check_output();
    endtask

    task automatic idle();
        apply_stimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    endtask

    // Directed sequence; every step queues expectations, then advances one edge.
    initial begin
        sbus.stall = 1'b0; sbus.branch_taken = 1'b0; sbus.branch_target = 8'd0;
        sbus.jump_valid = 1'b0; sbus.jump_target = 8'd0;
        sbus.trap_req = 1'b0; sbus.trap_ret = 1'b0;
        idle();
        reset = 1'b0;
        #1 reset = 1'b1;

        // Reset state
        expect_val("rst_pc", S_PC, 32'h0040_0000);
        expect_val("rst_valid", S_VALID, 32'd0);
        expect_val("rst_epc", S_EPC, 32'd0);
        expect_val("rst_cause", S_CAUSE, 32'd0);
        expect_val("rst_handler", S_HANDLER, 32'd0);
        expect_val("rst_halted", S_HALTED, 32'd0);
        expect_val("rst_adv", S_ADV, 32'd0);
        expect_val("rst_plus4", S_PLUS4, 32'h0040_0004);
        expect_val("rst_spc", S_SPC, 32'h0000_00F8);
        step();
        step();
        reset = 1'b0;

        // Boot cycle: valid rises, pc unchanged
        expect_val("boot_pc", S_PC, 32'h0040_0000);
        expect_val("boot_valid", S_VALID, 32'd1);
        expect_val("boot_adv", S_ADV, 32'd0);
        expect_val("boot_spc", S_SPC, 32'h0000_00F8);
        expect_val("boot_svalid", S_SVALID, 32'd1);
        step();

        // Sequential run, with the narrow instance wrapping
        expect_val("seq1_pc", S_PC, 32'h0040_0004);
        expect_val("seq1_adv", S_ADV, 32'd1);
        expect_val("wrap1_spc", S_SPC, 32'h0000_00FC);
        expect_val("wrap1_sadv", S_SADV, 32'd1);
        expect_val("wrap1_splus4", S_SPLUS4, 32'h0000_0000);
        step();
        expect_val("seq2_pc", S_PC, 32'h0040_0008);
        expect_val("wrap2_spc", S_SPC, 32'h0000_0000);
        expect_val("wrap2_sadv", S_SADV, 32'd2);
        step();
        expect_val("seq3_pc", S_PC, 32'h0040_000C);
        expect_val("wrap3_spc", S_SPC, 32'h0000_0004);
        expect_val("wrap3_sadv", S_SADV, 32'd3);
        step();
        expect_val("seq4_pc", S_PC, 32'h0040_0010);
        expect_val("seq4_adv", S_ADV, 32'd4);
        expect_val("wrap4_spc", S_SPC, 32'h0000_0008);
        expect_val("wrap4_sadv", S_SADV, 32'd0);
        step();

        // Stall holds a pending jump for three cycles
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b1, 1'b0, 32'd0, 1'b1, 32'h0040_0100, 1'b0, 1'b0);
            expect_val("stall_pc", S_PC, 32'h0040_0010);
            expect_val("stall_adv", S_ADV, 32'd4);
            step();
        end
        apply_stimulus(1'b0, 1'b0, 32'd0, 1'b1, 32'h0040_0100, 1'b0, 1'b0);
        expect_val("jump_pc", S_PC, 32'h0040_0100);
        expect_val("jump_adv", S_ADV, 32'd5);
        step();

        // Jump wins over branch
        apply_stimulus(1'b0, 1'b1, 32'h0040_0300, 1'b1, 32'h0040_0200, 1'b0, 1'b0);
        expect_val("jmp_over_br_pc", S_PC, 32'h0040_0200);
        expect_val("jmp_over_br_adv", S_ADV, 32'd6);
        step();
        apply_stimulus(1'b0, 1'b0, 32'd0, 1'b1, 32'h0040_0020, 1'b0, 1'b0);
        expect_val("to20_pc", S_PC, 32'h0040_0020);
        step();

        // Trap entry overrides stall
        apply_stimulus(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
        expect_val("trap_pc", S_PC, 32'h0040_0180);
        expect_val("trap_epc", S_EPC, 32'h0040_0020);
        expect_val("trap_cause", S_CAUSE, 32'd1);
        expect_val("trap_handler", S_HANDLER, 32'd1);
        expect_val("trap_adv", S_ADV, 32'd8);
        step();

        // Return from handler; cause is sticky
        apply_stimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1);
        expect_val("ret_pc", S_PC, 32'h0040_0020);
        expect_val("ret_handler", S_HANDLER, 32'd0);
        expect_val("ret_cause", S_CAUSE, 32'd1);
        expect_val("ret_adv", S_ADV, 32'd9);
        step();

        // trap_ret outside the handler is plain sequential
        expect_val("ret_in_run_pc", S_PC, 32'h0040_0024);
        expect_val("ret_in_run_handler", S_HANDLER, 32'd0);
        step();
        apply_stimulus(1'b0, 1'b0, 32'd0, 1'b1, 32'h0040_0030, 1'b0, 1'b0);
        expect_val("to30_pc", S_PC, 32'h0040_0030);
        expect_val("to30_adv", S_ADV, 32'd11);
        step();

        // Misaligned branch target traps with cause 2
        apply_stimulus(1'b0, 1'b1, 32'h0040_0042, 1'b0, 32'd0, 1'b0, 1'b0);
        expect_val("mis_br_pc", S_PC, 32'h0040_0180);
        expect_val("mis_br_epc", S_EPC, 32'h0040_0030);
        expect_val("mis_br_cause", S_CAUSE, 32'd2);
        expect_val("mis_br_handler", S_HANDLER, 32'd1);
        step();
        apply_stimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1);
        expect_val("ret2_pc", S_PC, 32'h0040_0030);
        expect_val("ret2_adv", S_ADV, 32'd13);
        step();

        // Misaligned branch masked by an aligned jump
        apply_stimulus(1'b0, 1'b1, 32'h0040_0042, 1'b1, 32'h0040_0050, 1'b0, 1'b0);
        expect_val("masked_pc", S_PC, 32'h0040_0050);
        expect_val("masked_handler", S_HANDLER, 32'd0);
        expect_val("masked_adv", S_ADV, 32'd14);
        step();

        // Misaligned jump target traps even under stall
        apply_stimulus(1'b1, 1'b0, 32'd0, 1'b1, 32'h0040_0061, 1'b0, 1'b0);
        expect_val("mis_j_pc", S_PC, 32'h0040_0180);
        expect_val("mis_j_epc", S_EPC, 32'h0040_0050);
        expect_val("mis_j_cause", S_CAUSE, 32'd2);
        expect_val("mis_j_adv", S_ADV, 32'd15);
        step();

        // Double fault halts
        apply_stimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
        expect_val("dbl_halted", S_HALTED, 32'd1);
        expect_val("dbl_valid", S_VALID, 32'd0);
        expect_val("dbl_pc", S_PC, 32'h0040_0180);
        expect_val("dbl_epc", S_EPC, 32'h0040_0050);
        expect_val("dbl_handler", S_HANDLER, 32'd0);
        expect_val("dbl_adv", S_ADV, 32'd15);
        step();

        // Halt ignores arbitrary inputs
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                           1'($urandom_range(0, 1)), $urandom,
                           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            expect_val("halt_pc", S_PC, 32'h0040_0180);
            expect_val("halt_halted", S_HALTED, 32'd1);
            expect_val("halt_adv", S_ADV, 32'd15);
            expect_val("halt_cause", S_CAUSE, 32'd2);
            step();
        end

        // Asynchronous reset takes effect without a clock edge
        idle();
        #2 reset = 1'b1;
        #1;
        expect_val("arst_pc", S_PC, 32'h0040_0000);
        expect_val("arst_valid", S_VALID, 32'd0);
        expect_val("arst_halted", S_HALTED, 32'd0);
        expect_val("arst_epc", S_EPC, 32'd0);
        expect_val("arst_cause", S_CAUSE, 32'd0);
        expect_val("arst_adv", S_ADV, 32'd0);
        check_output();
        @(posedge clk);
        #1 reset = 1'b0;

        // Recovery through boot
        expect_val("reboot_pc", S_PC, 32'h0040_0000);
        expect_val("reboot_valid", S_VALID, 32'd1);
        step();
        expect_val("reboot_seq_pc", S_PC, 32'h0040_0004);
        expect_val("reboot_seq_adv", S_ADV, 32'd1);
        step();

        // Plain branch
        apply_stimulus(1'b0, 1'b1, 32'h0040_0400, 1'b0, 32'd0, 1'b0, 1'b0);
        expect_val("branch_pc", S_PC, 32'h0040_0400);
        expect_val("branch_adv", S_ADV, 32'd2);
        expect_val("branch_plus4", S_PLUS4, 32'h0040_0404);
        step();
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule
